// File: rtl/async_sram_target.sv
// Bridges an asynchronous SRAM-style external master onto a synchronous
// request/ready internal bus. Pad inputs are synchronised before any decision.
`timescale 1ns/1ps

module async_sram_target #(
    parameter int N_SRAM_A  = 18,
    parameter int N_SRAM_DQ = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_SRAM_A-1:0]  padin_sram_a,
    input  logic [N_SRAM_DQ-1:0] padin_sram_dq,
    input  logic                 padin_sram_cs_n,
    input  logic                 padin_sram_oe_n,
    input  logic                 padin_sram_we_n,
    input  logic                 padin_sram_ub_n,
    input  logic                 padin_sram_lb_n,
    output logic [N_SRAM_DQ-1:0] padout_sram_dq,
    output logic [N_SRAM_DQ-1:0] padoe_sram_dq,
    output logic                 mem_req,
    output logic                 mem_write,
    output logic [N_SRAM_A-1:0]  mem_addr,
    output logic [N_SRAM_DQ-1:0] mem_wdata,
    output logic [1:0]           mem_wstrb,
    input  logic                 mem_ready,
    input  logic [N_SRAM_DQ-1:0] mem_rdata,
    input  logic                 err_clr,
    output logic                 err_overrun
);

    localparam int LANE = N_SRAM_DQ / 2;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_DRIVE,
        RD_DRAIN,
        WR_REQ
    } state_t;

    // Strobe vector order: {cs, oe, we, ub, lb}, all active-low.
    logic [4:0]           strb_m_q, strb_s_q;
    logic [N_SRAM_A-1:0]  addr_m_q, addr_s_q, addr_p_q;
    logic [N_SRAM_DQ-1:0] dq_m_q, dq_s_q, dq_p_q;
    // Previous-cycle synchronised {cs, we, ub, lb}, used for write commit.
    logic [3:0]           strb_p_q;

    state_t               state_q, state_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_write_q, mem_write_d;
    logic [N_SRAM_A-1:0]  mem_addr_q, mem_addr_d;
    logic [N_SRAM_DQ-1:0] mem_wdata_q, mem_wdata_d;
    logic [1:0]           mem_wstrb_q, mem_wstrb_d;
    logic [N_SRAM_DQ-1:0] padout_q, padout_d;
    logic [N_SRAM_DQ-1:0] padoe_q, padoe_d;
    logic                 err_q, err_d;

    logic                 cs_s, oe_s, we_s, ub_s, lb_s;
    logic                 cs_p, we_p, ub_p, lb_p;
    logic                 read_cond, wr_commit, overrun;
    logic [1:0]           wr_strb;
    logic [N_SRAM_DQ-1:0] lanes;

    assign {cs_s, oe_s, we_s, ub_s, lb_s} = strb_s_q;
    assign {cs_p, we_p, ub_p, lb_p}       = strb_p_q;

    assign read_cond = !cs_s && !oe_s && we_s;
    assign wr_commit = we_s && !we_p && !cs_p;
    assign wr_strb   = {~ub_p, ~lb_p};
    assign lanes     = {{LANE{~ub_s}}, {LANE{~lb_s}}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_m_q <= '1;
            strb_s_q <= '1;
            strb_p_q <= '1;
            addr_m_q <= '0;
            addr_s_q <= '0;
            addr_p_q <= '0;
            dq_m_q   <= '0;
            dq_s_q   <= '0;
            dq_p_q   <= '0;
        end else begin
            strb_m_q <= {padin_sram_cs_n, padin_sram_oe_n, padin_sram_we_n,
                         padin_sram_ub_n, padin_sram_lb_n};
            strb_s_q <= strb_m_q;
            strb_p_q <= {cs_s, we_s, ub_s, lb_s};
            addr_m_q <= padin_sram_a;
            addr_s_q <= addr_m_q;
            addr_p_q <= addr_s_q;
            dq_m_q   <= padin_sram_dq;
            dq_s_q   <= dq_m_q;
            dq_p_q   <= dq_s_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            padout_q    <= '0;
            padoe_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            padout_q    <= padout_d;
            padoe_q     <= padoe_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        padout_d    = padout_q;
        padoe_d     = '0;
        err_d       = err_q;
        overrun     = 1'b0;

        case (state_q)
            IDLE: begin
                // A commit with no byte lanes enabled is silently dropped.
                if (wr_commit && (wr_strb != 2'b00)) begin
                    state_d     = WR_REQ;
                    mem_req_d   = 1'b1;
                    mem_write_d = 1'b1;
                    mem_addr_d  = addr_p_q;
                    mem_wdata_d = dq_p_q;
                    mem_wstrb_d = wr_strb;
                end else if (read_cond) begin
                    state_d     = RD_REQ;
                    mem_req_d   = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = addr_s_q;
                    mem_wstrb_d = '0;
                end
            end
            RD_REQ: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    if (read_cond) begin
                        state_d  = RD_DRIVE;
                        padout_d = mem_rdata;
                        padoe_d  = lanes;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cs_s) begin
                    state_d = RD_DRAIN;
                end
            end
            RD_DRIVE: begin
                if (!read_cond) begin
                    state_d = IDLE;
                end else if (addr_s_q != mem_addr_q) begin
                    state_d     = RD_REQ;
                    mem_req_d   = 1'b1;
                    mem_write_d = 1'b0;
                    mem_addr_d  = addr_s_q;
                end else begin
                    padoe_d = lanes;
                end
            end
            RD_DRAIN: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            WR_REQ: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase

        if (wr_commit && (state_q != IDLE)) begin
            overrun = 1'b1;
        end
        if (err_clr) begin
            err_d = 1'b0;
        end
        if (overrun) begin
            err_d = 1'b1;
        end
    end

    assign mem_req        = mem_req_q;
    assign mem_write      = mem_write_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_wstrb      = mem_wstrb_q;
    assign padout_sram_dq = padout_q;
    assign padoe_sram_dq  = padoe_q;
    assign err_overrun    = err_q;

endmodule

// File: doc/async_sram_target.md
ASYNC_SRAM_TARGET -- requirements
Module: async_sram_target

Interface
REQ-001 SHALL have parameter N_SRAM_A, default 18, width of external address bus and internal word address.
REQ-002 SHALL have parameter N_SRAM_DQ, default 16, external data width; only 16 is supported (two byte lanes).
REQ-003 SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-004 padin_sram_a  input  N_SRAM_A  address from external master.
REQ-005 padin_sram_dq  input  N_SRAM_DQ  write data from external master.
REQ-006 padin_sram_cs_n, padin_sram_oe_n, padin_sram_we_n, padin_sram_ub_n, padin_sram_lb_n  input  1 each  active-low strobes from external master.
REQ-007 padout_sram_dq  output  N_SRAM_DQ  read data to pads.
REQ-008 padoe_sram_dq  output  N_SRAM_DQ  per-bit pad output enable.
REQ-009 mem_req  output  1  internal bus request, held high until accepted.
REQ-010 mem_write  output  1  1 = write, 0 = read; valid while mem_req.
REQ-011 mem_addr  output  N_SRAM_A  internal halfword address.
REQ-012 mem_wdata  output  N_SRAM_DQ  write data.
REQ-013 mem_wstrb  output  2  byte enables, bit 1 = upper byte.
REQ-014 mem_ready  input  1  request accepted/completed this cycle when mem_req high.
REQ-015 mem_rdata  input  N_SRAM_DQ  read data, valid in the mem_ready cycle.
REQ-016 err_clr  input  1  clears err_overrun.
REQ-017 err_overrun  output  1  sticky: external access lost.

Function
REQ-018 All padin_* signals SHALL pass a 2-flop synchronizer; "_s" denotes stage-2 outputs; all decisions SHALL use only _s values.
REQ-019 FSM states SHALL be IDLE, RD_REQ, RD_DRIVE, RD_DRAIN, WR_REQ.
REQ-020 Read condition: cs_s=0, oe_s=0, we_s=1.
REQ-021 IDLE: read condition true -> latch addr_s, enter RD_REQ with mem_req=1, mem_write=0 on the next edge.
REQ-022 Write commit: we_s 0->1 transition, with cs_s=0 in the previous cycle; addr, dq, {~ub,~lb} SHALL be taken from the previous cycle's _s values (last values while we_s low).
REQ-023 IDLE + write commit -> WR_REQ with mem_req=1, mem_write=1, mem_wstrb={~ub,~lb} on the next edge; a write with mem_wstrb=2'b00 SHALL be discarded without a request.
REQ-024 mem_req, mem_write, mem_addr, mem_wdata, mem_wstrb SHALL remain stable from assertion until the cycle mem_ready=1; mem_req SHALL deassert on the following edge.
REQ-025 WR_REQ + mem_ready -> IDLE.
REQ-026 RD_REQ + mem_ready: read condition still true -> RD_DRIVE; padout_sram_dq := mem_rdata on the same edge. Read condition false -> IDLE, data discarded.
REQ-027 RD_DRIVE: padoe_sram_dq[15:8] = {8{~ub_s}}, padoe_sram_dq[7:0] = {8{~lb_s}}, registered; both lanes 0 in all other states.
REQ-028 RD_DRIVE: read condition false -> IDLE, padoe = 0 on the same edge.
REQ-029 RD_DRIVE: addr_s differs from the latched address while the read condition holds -> RD_REQ with the new address, padoe = 0, padout_sram_dq held.
REQ-030 A write commit detected in any state other than IDLE SHALL be dropped and SHALL set err_overrun.
REQ-031 Read latency SHALL be 2 sync cycles + 1 cycle to mem_req + memory wait + 1 cycle to padoe; external master OE access time is (4 + wait) clk periods.
REQ-032 err_clr=1 SHALL clear err_overrun on the next edge; a simultaneous set SHALL win.
REQ-033 RD_DRAIN SHALL be entered from RD_REQ only, if cs_s rises before mem_ready; it SHALL hold mem_req until mem_ready, then go to IDLE with no drive.

Reset
REQ-034 rst_n=0 SHALL asynchronously force: state IDLE, mem_req=0, mem_write=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, padout_sram_dq=0, padoe_sram_dq=0, err_overrun=0.
REQ-035 rst_n=0 SHALL also set strobe synchronizers to 1 (inactive) and address/data synchronizers to 0, so that no spurious edge is seen at reset release.
REQ-036 Reset asserted mid-request SHALL drop mem_req immediately; the internal bus SHALL tolerate an abandoned request.

Verification
REQ-037 Write: a=0x00123, dq=0xBEEF, ub=lb=0, WE low 6 clk -> one mem_req, write=1, addr 0x00123, wdata 0xBEEF, wstrb 2'b11.
REQ-038 Byte write: lb=0, ub=1, dq=0x12AB -> wstrb 2'b01, wdata 0x12AB; ub=lb=1 -> no mem_req.
REQ-039 Read, mem_ready 2 cycles after req with rdata=0x5A5A, ub=0, lb=1 -> padoe=0xFF00, padout=0x5A5A, 6 clk after OE falls at the pad.
REQ-040 Read with address change 0x10 -> 0x11 while OE low -> padoe 0, second read request to 0x11, then drive resumes with the new data.
REQ-041 CS rises during RD_REQ, mem_ready delayed 5 cycles -> mem_req held through 5 cycles, padoe never asserts, returns to IDLE; write during this window -> err_overrun=1; err_clr -> 0.
REQ-042 rst_n pulsed low during RD_DRIVE -> padoe 0 and mem_req 0 immediately; no access occurs after release until a new strobe edge.
